// File: rtl/tis_port_ctrl.sv
// tis_port_ctrl: blocking port sequencer for one TIS-100 node.
// ANY_RR_EN selects round-robin ANY grant; otherwise fixed 0>1>2>3.
module tis_port_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [2:0]        rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              busy,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [3:0]        in_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        last_port,
  output logic              last_vld
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, WR_WAIT, DONE_RD, DONE_WR
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        mask_q, dec_mask;
  logic [3:0]        req, gnt;
  logic              any_q, dec_any;
  logic              ld, fire;
  logic [2:0]        dec_sel, wr_sel_q;
  logic              wr_pend_q;
  logic [DATA_W-1:0] wr_q, rd_q, grab;
  logic [1:0]        gnt_idx, lp_q;
  logic              lv_q;
`ifdef ANY_RR_EN
  logic [1:0]        rr_q;
`endif

  // Decode the selector into an eligible-port mask; empty mask means NIL.
  always_comb begin
    if (state_q == IDLE)
      dec_sel = rd_req ? rd_sel : wr_sel;
    else
      dec_sel = wr_sel_q;
    dec_mask = 4'b0000;
    dec_any  = 1'b0;
    unique case (1'b1)
      !dec_sel[2]: dec_mask = 4'b0001 << dec_sel[1:0];
      dec_sel == 3'd4: begin
        dec_mask = 4'b1111;
        dec_any  = 1'b1;
      end
      dec_sel == 3'd5:
        dec_mask = lv_q ? (4'b0001 << lp_q) : 4'b0000;
      default: dec_mask = 4'b0000;
    endcase
  end

  // Pick exactly one port among those ready to transfer.
  always_comb begin
    req = 4'b0000;
    if (state_q == RD_WAIT) req = in_valid & mask_q;
    if (state_q == WR_WAIT) req = out_ready & mask_q;
    gnt_idx = 2'd0;
`ifdef ANY_RR_EN
    for (int i = 3; i >= 0; i--)
      if (req[rr_q + 2'(i)]) gnt_idx = rr_q + 2'(i);
`else
    for (int i = 3; i >= 0; i--)
      if (req[i]) gnt_idx = 2'(i);
`endif
    fire = |req;
    gnt  = 4'b0001 << gnt_idx;
  end

  // Handshake outputs narrow to the granted port once one fires.
  always_comb begin
    in_ready  = 4'b0000;
    out_valid = 4'b0000;
    if (state_q == RD_WAIT) in_ready = fire ? gnt : mask_q;
    if (state_q == WR_WAIT) out_valid = fire ? gnt : mask_q;
  end

  // Incoming data mux for the granted link.
  always_comb begin
    unique case (gnt_idx)
      2'd0: grab = in_data0;
      2'd1: grab = in_data1;
      2'd2: grab = in_data2;
      default: grab = in_data3;
    endcase
  end

  assign busy      = state_q != IDLE;
  assign rd_done   = state_q == DONE_RD;
  assign wr_done   = state_q == DONE_WR;
  assign rd_data   = rd_q;
  assign out_data  = wr_q;
  assign last_port = lp_q;
  assign last_vld  = lv_q;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; a latched write is decoded while read completes.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          ld      = 1'b1;
          state_d = |dec_mask ? RD_WAIT : DONE_RD;
        end else if (wr_req) begin
          ld      = 1'b1;
          state_d = |dec_mask ? WR_WAIT : DONE_WR;
        end
      end
      RD_WAIT: if (fire) state_d = DONE_RD;
      WR_WAIT: if (fire) state_d = DONE_WR;
      DONE_RD: begin
        if (wr_pend_q) begin
          ld      = 1'b1;
          state_d = |dec_mask ? WR_WAIT : DONE_WR;
        end else begin
          state_d = IDLE;
        end
      end
      DONE_WR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, read capture and LAST tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= 4'b0000;
      any_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_sel_q  <= 3'd0;
      wr_q      <= '0;
      rd_q      <= '0;
      lp_q      <= 2'd0;
      lv_q      <= 1'b0;
    end else begin
      if (ld) begin
        mask_q <= dec_mask;
        any_q  <= dec_any;
      end
      if (state_q == IDLE && wr_req) begin
        wr_q      <= wr_data;
        wr_sel_q  <= wr_sel;
        wr_pend_q <= rd_req;
      end
      if (state_q == DONE_RD) wr_pend_q <= 1'b0;
      if (state_q == IDLE && rd_req && dec_mask == 4'b0000)
        rd_q <= '0;
      if (state_q == RD_WAIT && fire) rd_q <= grab;
      if (fire && any_q) begin
        lp_q <= gnt_idx;
        lv_q <= 1'b1;
      end
    end
  end

`ifdef ANY_RR_EN
  // Rotate the ANY start point past the port just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rr_q <= 2'd0;
    else if (fire && any_q)  rr_q <= gnt_idx + 2'd1;
  end
`endif

endmodule

// File: tb/tb_tis_port_ctrl.sv
// tb_tis_port_ctrl: vector table, corner sequences and random
// transactions against a transaction-level port model.
module tb_tis_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req = 1'b0;
  logic [2:0] rd_sel = 3'd0;
  logic [7:0] rd_data;
  logic       rd_done;
  logic       wr_req = 1'b0;
  logic [2:0] wr_sel = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_done;
  logic       busy;
  logic [3:0] in_valid = 4'b0000;
  logic [7:0] nd [4];
  logic [3:0] in_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready = 4'b0000;
  logic [1:0] last_port;
  logic       last_vld;

  int n_chk = 0;
  int n_fail = 0;

  int m_ptr;
  bit m_lv;
  int m_lp;

  tis_port_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_done(wr_done),
    .busy(busy),
    .in_valid(in_valid),
    .in_data0(nd[0]), .in_data1(nd[1]),
    .in_data2(nd[2]), .in_data3(nd[3]),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .last_port(last_port), .last_vld(last_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void resolve(input logic [2:0] s,
      output logic [3:0] set, output bit any);
    any = 0;
    if (s < 3'd4) set = 4'(1 << s);
    else if (s == 3'd4) begin set = 4'b1111; any = 1; end
    else if (s == 3'd5) set = m_lv ? 4'(1 << m_lp) : 4'b0000;
    else set = 4'b0000;
  endfunction

  function automatic int pick(input logic [3:0] c);
`ifdef ANY_RR_EN
    for (int d = 0; d < 4; d++)
      if (c[(m_ptr + d) % 4]) return (m_ptr + d) % 4;
`else
    for (int d = 0; d < 4; d++)
      if (c[d]) return d;
`endif
    return 0;
  endfunction

  function automatic void served_any(input int g);
    m_lp  = g;
    m_lv  = 1;
    m_ptr = (g + 1) % 4;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rd_req = 0; wr_req = 0;
    in_valid = 0; out_ready = 0;
    m_ptr = 0; m_lv = 0; m_lp = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One read, one write, or a read with a latched write.
  task automatic txn(
      input bit do_rd, input logic [2:0] rs,
      input bit do_wr, input logic [2:0] ws,
      input logic [7:0] wd, input bit rnd,
      input logic [3:0] vin, input logic [3:0] vout,
      output int rd_cyc, output int wr_cyc,
      output logic [3:0] m1, output logic [3:0] hs,
      output logic [7:0] rdv);
    int ph, rd_at, wr_at, wr_start, g, c;
    bit wr_todo, rany, wany, fin;
    logic [3:0] rset, wset, cand, e_ir, e_ov;
    logic [7:0] e_rd;
    rd_cyc = -1; wr_cyc = -1; m1 = 0; hs = 0; rdv = 0;
    rd_at = -1; wr_at = -1; e_rd = 0; ph = 2;
    wr_todo = do_wr; wr_start = do_rd ? -1 : 1;
    wset = 0; wany = 0; rset = 0; rany = 0; fin = 0;
    @(negedge clk);
    rd_req = do_rd; rd_sel = rs;
    wr_req = do_wr; wr_sel = ws; wr_data = wd;
    in_valid = vin; out_ready = vout;
    #1;
    check("idle_busy", busy, 0);
    if (do_rd) begin
      resolve(rs, rset, rany);
      if (rset == 0) begin
        rd_at = 1;
        wr_start = 2;
      end else ph = 0;
    end
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      rd_req = 0; wr_req = 0;
      if (rnd) begin
        in_valid  = 4'($urandom);
        out_ready = 4'($urandom);
      end
      #1;
      check("last_vld", last_vld, m_lv);
      if (m_lv) check("last_port", last_port, m_lp);
      if (wr_todo && c == wr_start) begin
        wr_todo = 0;
        resolve(ws, wset, wany);
        if (wset == 0) wr_at = c;
        else ph = 1;
      end
      e_ir = 0; e_ov = 0;
      if (ph == 0) begin
        cand = rset & in_valid;
        if (cand != 0) begin
          g = pick(cand);
          e_ir = 4'(1 << g);
          e_rd = nd[g];
          if (rany) served_any(g);
          rd_at = c + 1;
          wr_start = c + 2;
          ph = 2;
        end else e_ir = rset;
      end else if (ph == 1) begin
        check("out_data", out_data, wd);
        cand = wset & out_ready;
        if (cand != 0) begin
          g = pick(cand);
          e_ov = 4'(1 << g);
          if (wany) served_any(g);
          wr_at = c + 1;
          ph = 2;
        end else e_ov = wset;
      end
      check("in_ready", in_ready, e_ir);
      check("out_valid", out_valid, e_ov);
      check("rd_done", rd_done, c == rd_at);
      check("wr_done", wr_done, c == wr_at);
      if (c == rd_at) check("rd_data", rd_data, e_rd);
      if (rd_done) begin rd_cyc = c; rdv = rd_data; end
      if (wr_done) wr_cyc = c;
      if (c == 1) m1 = in_ready | out_valid;
      hs |= (in_ready & in_valid) | (out_valid & out_ready);
      fin = (ph == 2) && !wr_todo && c > rd_at && c > wr_at;
      check("busy", busy, !fin);
      if (fin) break;
    end
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL txn_timeout: no completion after 200 cycles");
    end
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] sel;
    logic [3:0] vr;
    logic [7:0] d;
    logic [3:0] m1;
    int         done;
    logic [7:0] rdv;
  } vec_t;

  vec_t tbl [11];
  int eg [3];

  initial begin
    int rc, wc;
    logic [3:0] m1, hs;
    logic [7:0] rv;
    bit dr, dw;

    nd[0] = 8'h3C; nd[1] = 8'h96; nd[2] = 8'h5A; nd[3] = 8'hC3;
    tbl[0]  = '{0, 3'd2, 4'b0100, 8'h00, 4'b0100, 2, 8'h5A};
    tbl[1]  = '{0, 3'd5, 4'b1111, 8'h00, 4'b0000, 1, 8'h00};
    tbl[2]  = '{1, 3'd6, 4'b1111, 8'h77, 4'b0000, 1, 8'h00};
    tbl[3]  = '{0, 3'd0, 4'b0001, 8'h00, 4'b0001, 2, 8'h3C};
    tbl[4]  = '{0, 3'd3, 4'b1111, 8'h00, 4'b1000, 2, 8'hC3};
    tbl[5]  = '{1, 3'd1, 4'b0010, 8'hA5, 4'b0010, 2, 8'h00};
    tbl[6]  = '{1, 3'd7, 4'b1111, 8'h12, 4'b0000, 1, 8'h00};
    tbl[7]  = '{0, 3'd6, 4'b1111, 8'h00, 4'b0000, 1, 8'h00};
    tbl[8]  = '{1, 3'd3, 4'b1000, 8'h9E, 4'b1000, 2, 8'h00};
    tbl[9]  = '{0, 3'd1, 4'b1111, 8'h00, 4'b0010, 2, 8'h96};
    tbl[10] = '{1, 3'd5, 4'b1111, 8'h66, 4'b0000, 1, 8'h00};
`ifdef ANY_RR_EN
    eg = '{0, 1, 2};
`else
    eg = '{0, 0, 0};
`endif

    do_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_last_vld", last_vld, 0);
    check("rst_last_port", last_port, 0);

    foreach (tbl[i]) begin
      txn(!tbl[i].wr, tbl[i].sel, tbl[i].wr, tbl[i].sel,
          tbl[i].d, 0, tbl[i].vr, tbl[i].vr, rc, wc, m1, hs, rv);
      check($sformatf("tbl%0d_m1", i), m1, tbl[i].m1);
      check($sformatf("tbl%0d_hs", i), hs, tbl[i].m1);
      check($sformatf("tbl%0d_done", i),
            tbl[i].wr ? wc : rc, tbl[i].done);
      if (!tbl[i].wr)
        check($sformatf("tbl%0d_rdv", i), rv, tbl[i].rdv);
    end

    // ANY reads with every neighbour offering
    do_reset();
    for (int k = 0; k < 3; k++) begin
      txn(1, 3'd4, 0, 3'd0, 8'h00, 0, 4'b1111, 4'b0000,
          rc, wc, m1, hs, rv);
      check($sformatf("any%0d_grant", k), hs, 4'(1 << eg[k]));
      check($sformatf("any%0d_onehot", k), $countones(m1), 1);
      check($sformatf("any%0d_data", k), rv, nd[eg[k]]);
    end
    check("any_last_port", last_port, eg[2]);

    // ANY write with only odd links ready, then LAST write
    do_reset();
    txn(0, 3'd0, 1, 3'd4, 8'h33, 0, 4'b0000, 4'b1010,
        rc, wc, m1, hs, rv);
    check("anyw_hs", hs, 4'b0010);
    check("anyw_done", wc, 2);
    check("anyw_last", last_port, 1);
    txn(0, 3'd0, 1, 3'd5, 8'h44, 0, 4'b0000, 4'b1111,
        rc, wc, m1, hs, rv);
    check("lastw_ov", m1, 4'b0010);
    check("lastw_hs", hs, 4'b0010);

    // LAST/NIL right after reset complete in one cycle
    do_reset();
    txn(1, 3'd5, 0, 3'd0, 8'h00, 0, 4'b1111, 4'b1111,
        rc, wc, m1, hs, rv);
    check("lastr_done", rc, 1);
    check("lastr_data", rv, 0);
    check("lastr_ir", hs, 0);
    txn(0, 3'd0, 1, 3'd6, 8'h5F, 0, 4'b1111, 4'b1111,
        rc, wc, m1, hs, rv);
    check("nilw_done", wc, 1);
    check("nilw_ov", hs, 0);

    // read and write in the same cycle
    nd[0] = 8'h11;
    txn(1, 3'd0, 1, 3'd3, 8'h22, 0, 4'b0001, 4'b1000,
        rc, wc, m1, hs, rv);
    check("rw_rd_done", rc, 2);
    check("rw_wr_done", wc, 4);
    check("rw_rd_data", rv, 8'h11);
    check("rw_hs", hs, 4'b1001);

    // reset pulled mid-wait
    txn(1, 3'd4, 0, 3'd0, 8'h00, 0, 4'b0100, 4'b0000,
        rc, wc, m1, hs, rv);
    check("pre_rst_vld", last_vld, 1);
    @(negedge clk);
    rd_req = 1; rd_sel = 3'd1; in_valid = 4'b0000;
    @(negedge clk);
    rd_req = 0;
    #1;
    check("wait_ir", in_ready, 4'b0010);
    check("wait_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_ir", in_ready, 0);
    check("async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_lv = 0; m_lp = 0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_vld", last_vld, 0);
    check("post_rst_done", rd_done, 0);

    // random traffic against the model
    for (int n = 0; n < 150; n++) begin
      for (int p = 0; p < 4; p++) nd[p] = 8'($urandom);
      dr = 1'($urandom);
      dw = dr ? 1'($urandom) : 1'b1;
      txn(dr, 3'($urandom), dw, 3'($urandom), 8'($urandom), 1,
          4'($urandom), 4'($urandom), rc, wc, m1, hs, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tis_port_ctrl.md
# tis_port_ctrl

Blocking-port sequencer for one TIS-100 node. Sits between the node's execution path and its four 8-bit neighbour links and turns each port read or write (explicit port, ANY, LAST, NIL) into a valid/ready handshake. The node stalls until the handshake completes. ANY accesses are shared fairly among the four links, and the LAST port is tracked here.

## Interface
- DATA_W, 8, link and data width
- clk  in  1  node clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  read request, sampled in IDLE
- rd_sel  in  3  read source: 0–3 port, 4 ANY, 5 LAST, 6/7 NIL
- rd_data  out  DATA_W  read result, valid while rd_done=1
- rd_done  out  1  one-cycle completion pulse
- wr_req  in  1  write request, sampled in IDLE
- wr_sel  in  3  write destination, same encoding as rd_sel
- wr_data  in  DATA_W  write value, captured with wr_req
- wr_done  out  1  one-cycle completion pulse
- busy  out  1  state ≠ IDLE; the execution path holds its PC while high
- in_valid  in  4  neighbour n offers data
- in_data0..in_data3  in  DATA_W each  neighbour data
- in_ready  out  4  node accepts from neighbour n
- out_valid  out  4  node offers out_data to neighbour n
- out_data  out  DATA_W  shared outgoing data
- out_ready  in  4  neighbour n accepts
- last_port  out  2  port of the most recent ANY transfer
- last_vld  out  1  last_port is meaningful

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, DONE_RD, DONE_WR.
- IDLE:
  - rd_req has priority over wr_req, which supports MOV src,dst ordering. A concurrent wr_req is latched and serviced starting the cycle after rd_done.
  - wr_data is latched together with the pending write.
- Request decode in IDLE:
  - NIL, or LAST with last_vld=0 → DONE_x directly. Reads return 0; write data is discarded.
  - LAST with last_vld=1 → treated as port last_port.
  - Otherwise the port mask is captured: one-hot for ports 0–3, 4'b1111 for ANY.
- RD_WAIT:
  - in_ready = mask.
  - Transfer when in_valid & in_ready is nonzero. If several ports fire at once (ANY only), the grant picks exactly one. in_ready is masked combinationally to the granted port so the others do not transfer.
  - The granted in_data is registered into rd_data, then → DONE_RD.
- WR_WAIT:
  - out_data = latched value.
  - out_valid = mask gated by the grant over out_ready, so exactly one port sees valid & ready.
  - → DONE_WR on transfer.
- DONE_RD / DONE_WR:
  - Assert rd_done / wr_done for one cycle.
  - Next state is WR_WAIT (or its NIL/LAST decode) if a write is latched, else IDLE.
- Grant for ANY:
  - Round-robin starting at rr_ptr, with wrap 3→0.
  - After an ANY grant to port g: rr_ptr ← (g+1) mod 4, last_port ← g, last_vld ← 1.
  - Explicit-port and LAST transfers change neither rr_ptr nor last_port.
- A neighbour deasserting valid or ready mid-wait causes no transfer. The block waits indefinitely, and there is no timeout.
- Reset values: state IDLE, rd_data 0, rd_done 0, wr_done 0, busy 0, in_ready 0, out_valid 0, out_data 0, last_port 0, last_vld 0, rr_ptr 0.
- Asserting rst_n low mid-handshake drops all valid and ready outputs immediately (asynchronous). A pending request is lost.

## Timing
- Request sampled at cycle 0. busy=1 from cycle 1.
- Port access: the handshake can complete at the earliest in cycle 1. rd_done/wr_done assert in cycle T+1, where T is the transfer cycle.
- Minimum latency is 2 cycles; NIL/LAST-invalid completes in 1 cycle.
- New request accepted the cycle after done. Back-to-back read+write with both ports already pending: rd_done at 2, wr_done at 4.
- rd_data holds its value until the next read completes.

## Configuration
- ANY_RR_EN defined: round-robin ANY arbitration as described.
- ANY_RR_EN undefined: fixed priority 0>1>2>3. rr_ptr is removed; last_port/last_vld behave unchanged.

## Test plan
- Reset, then rd_req rd_sel=2 with in_valid[2]=1 and in_data2=8'h5A → in_ready=4'b0100 at cycle 1, rd_done with rd_data=8'h5A at cycle 2, busy low at 3.
- rd_sel=4 (ANY) with in_valid=4'b1111, three times in a row → grants 0, 1, 2 (round-robin). last_port=2, and exactly one in_ready bit is high per transfer.
- wr_req wr_sel=4 wr_data=8'h33 with out_ready=4'b1010 and rr_ptr=0 → only out_valid[1] fires. wr_done follows, last_port=1. A following wr_sel=5 write goes to port 1 only.
- rd_sel=5 right after reset → rd_done at cycle 1 with rd_data=0, no in_ready asserted. wr_sel=6 → wr_done at cycle 1, out_valid stays 0.
- Simultaneous rd_req (port 0, data 8'h11) and wr_req (port 3, 8'h22) with both neighbours ready → rd_done at cycle 2, then out_data=8'h22 on port 3, wr_done at cycle 4.
- rst_n pulled low in RD_WAIT with in_ready[1]=1 → in_ready=0 immediately. After release: IDLE, busy=0, last_vld=0.
